// File: rtl/capiano_pkg.sv
// Shared constants for the camera-piano event path: event byte layout used by
// both the key event encoder and the UART controller, plus encoder FSM states.
package capiano_pkg;

  localparam int KEY_NUM      = 40;
  localparam int EV_PRESS_BIT = 7;
  localparam int EV_IDX_LSB   = 0;
  localparam int EV_IDX_W     = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } kee_state_t;

  // Pack a key event: press flag on top, reserved bit zero, key index low.
  function automatic logic [7:0] make_event(input logic press,
                                            input logic [EV_IDX_W-1:0] idx);
    logic [7:0] ev;
    ev = '0;
    ev[EV_PRESS_BIT] = press;
    ev[EV_IDX_LSB +: EV_IDX_W] = idx;
    return ev;
  endfunction

endpackage

// File: rtl/key_event_encoder_if.sv
// Valid/ready byte stream carrying key events towards the UART byte sender.
interface key_event_encoder_if;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/key_event_encoder.sv
// Debounces the per-frame key vector and streams one byte per committed
// press/release, scanning keys in ascending order once per accepted frame.
module key_event_encoder
  import capiano_pkg::*;
#(
  parameter int NUM_KEYS       = KEY_NUM,
  parameter int STABLE_SAMPLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_down,
  input  logic                sample_en,
  key_event_encoder_if.master evt,
  output logic [NUM_KEYS-1:0] stable_keys,
  output logic                busy,
  output logic [7:0]          drop_cnt
);

  localparam int                CNT_W     = $clog2(STABLE_SAMPLES + 1);
  localparam logic [5:0]        LAST_IDX  = 6'(NUM_KEYS - 1);
  localparam logic [CNT_W:0]    COMMIT_AT = (CNT_W + 1)'(STABLE_SAMPLES);

  kee_state_t          state_q, state_d;
  logic [NUM_KEYS-1:0] sample_q, sample_d;
  logic [NUM_KEYS-1:0] stable_q, stable_d;
  logic [5:0]          idx_q, idx_d;
  logic [7:0]          out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [7:0]          drop_q, drop_d;

  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

  logic [CNT_W-1:0]    cnt_cur;
  logic [CNT_W:0]      cnt_inc;
  logic                cnt_wr_en;
  logic [CNT_W-1:0]    cnt_wr_val;

  assign cnt_cur = cnt_q[idx_q];
  assign cnt_inc = {1'b0, cnt_cur} + (CNT_W + 1)'(1);

  // Only the key under evaluation ever has its counter rewritten.
  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_cnt
      assign cnt_d[gi] = (cnt_wr_en && (idx_q == 6'(gi))) ? cnt_wr_val : cnt_q[gi];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    stable_d    = stable_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    drop_d      = drop_q;
    cnt_wr_en   = 1'b0;
    cnt_wr_val  = '0;

    if (sample_en && (state_q != IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (sample_en) begin
          sample_d = key_down;
          idx_d    = '0;
          state_d  = SCAN;
        end
      end

      SCAN: begin
        cnt_wr_en = 1'b1;
        if (sample_q[idx_q] == stable_q[idx_q]) begin
          cnt_wr_val = '0;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end else if (cnt_inc == COMMIT_AT) begin
          // The new debounced state equals the sample, since they differed.
          stable_d[idx_q] = sample_q[idx_q];
          cnt_wr_val      = '0;
          out_data_d      = make_event(sample_q[idx_q], idx_q);
          out_valid_d     = 1'b1;
          state_d         = EMIT;
        end else begin
          cnt_wr_val = cnt_inc[CNT_W-1:0];
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end

      EMIT: begin
        if (evt.out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = SCAN;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sample_q    <= '0;
      stable_q    <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      stable_q    <= stable_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign evt.out_valid = out_valid_q;
  assign evt.out_data  = out_data_q;
  assign stable_keys   = stable_q;
  assign busy          = (state_q != IDLE);
  assign drop_cnt      = drop_q;

endmodule

// File: doc/key_event_encoder.md
# key_event_encoder

Converts the 40-bit per-frame `key_down` vector from the camera key detector into debounced press/release events, one byte per event, on a valid/ready stream for the UART byte sender. It sits between `camera_ctrl` and `uart_ctrl`. Per-key debounce filters single-frame finger flicker, and the encoder sends only state changes rather than the full vector every frame.

## Interface
- `NUM_KEYS`, default 40: number of keys; must be ≤ 64.
- `STABLE_SAMPLES`, default 3: consecutive differing samples needed to commit a key change; must be ≥ 1.
- `clk`, input, 1: system clock (`clk24` domain).
- `rst`, input, 1: reset; synchronous, active-high.
- `key_down`, input, NUM_KEYS: raw key vector from the camera detector; sampled only on `sample_en`.
- `sample_en`, input, 1: one-cycle strobe, once per camera frame.
- `out_valid`, output, 1: event byte available.
- `out_ready`, input, 1: consumer accepts the byte.
- `out_data`, output, 8: event byte.
  - bit 7: 1 = press, 0 = release.
  - bit 6: 0.
  - bits 5:0: key index.
- `stable_keys`, output, NUM_KEYS: debounced key state.
- `busy`, output, 1: scan in progress (any state other than IDLE).
- `drop_cnt`, output, 8: saturating count of ignored `sample_en` strobes.

## Operation
- Registers:
  - `sample` (NUM_KEYS bits).
  - `stable_keys`.
  - per-key counter `cnt[k]`, width clog2(STABLE_SAMPLES+1).
  - scan index `idx`, 6 bits.
  - `out_data`, `out_valid`, `drop_cnt`.
- FSM states: IDLE, SCAN, EMIT.
- IDLE:
  - On `sample_en`: latch `key_down` into `sample`, set `idx` = 0, go to SCAN.
  - Otherwise hold.
- SCAN, evaluating key `idx` in one cycle:
  - If `sample[idx]` == `stable_keys[idx]`: set `cnt[idx]` = 0. If `idx` == NUM_KEYS-1, go to IDLE; else `idx`++.
  - Else if `cnt[idx]+1` == STABLE_SAMPLES (a commit):
    - toggle `stable_keys[idx]`;
    - set `cnt[idx]` = 0;
    - load `out_data` = {new state, 1'b0, idx};
    - set `out_valid` = 1;
    - go to EMIT.
  - Else: `cnt[idx]`++, then advance `idx` or go to IDLE exactly as in the equal case.
- EMIT:
  - Hold `out_valid` and `out_data` constant until `out_valid && out_ready`.
  - On that transfer cycle: clear `out_valid`. If `idx` == NUM_KEYS-1, go to IDLE; else `idx`++ and go to SCAN.
- `sample_en` while `busy`: the strobe is ignored and `sample` is unchanged. `drop_cnt`++, saturating at 255.
- Each key produces at most one event per sample. Events are emitted in ascending key order.
- With STABLE_SAMPLES = 1, every differing sample commits immediately.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0.
  - `stable_keys` = 0, all `cnt` = 0, `sample` = 0.
  - `busy` = 0, `drop_cnt` = 0, state = IDLE.
- Reset during SCAN or EMIT aborts the scan. Any pending event is lost and `out_valid` is 0 the cycle after `rst`.
- `sample_en` at cycle t:
  - `busy` rises at t+1.
  - With no stalls, key k is evaluated at cycle t+1+k.
  - If key k commits, `out_valid` is seen high at t+2+k.
- A scan with no events lasts exactly NUM_KEYS cycles. `busy` drops at t+1+NUM_KEYS and the next `sample_en` is accepted from that cycle.
- Each event adds 1 cycle plus the wait for `out_ready`. With `out_ready` tied high, each event costs exactly 1 extra cycle.
- `out_ready` may be asserted before `out_valid`. A transfer only occurs when both are high.
- `stable_keys` updates on the same edge that raises `out_valid` for that event.
- `sample_en` on the same cycle as a transfer that ends the scan (EMIT with `idx` == NUM_KEYS-1): this counts as busy, so the strobe is dropped.

## Structure
- Shared package `capiano_pkg`:
  - `KEY_NUM` = 40.
  - Event bit positions: `EV_PRESS_BIT` = 7, `EV_IDX_LSB` = 0, `EV_IDX_W` = 6.
  - FSM state enum `kee_state_t` (IDLE, SCAN, EMIT).
  - The same constants are consumed by `uart_ctrl`.
- Single flat module, no sub-module. The counter array and scanner are small enough to keep inline.

## Test plan
- Key 5 held high for 3 strobes, `out_ready` = 1:
  - no event after strobes 1 and 2;
  - after strobe 3, `out_data` = 0x85 with `out_valid` high exactly 1 cycle, at cycle t+7;
  - `stable_keys[5]` = 1.
- Key 5 pattern 1,1,0,1,1,1 over 6 strobes: the counter clears on the 0, so the only event is 0x85, after strobe 6.
- Keys 0 and 39 both commit press, then both commit release; `out_ready` = 0 for 10 cycles:
  - 0x80 is held stable for 10 cycles, then 0xA7 follows;
  - on release the bytes are 0x00 then 0x27.
- `sample_en` pulsed at t and at t+10 with no events: the second strobe is dropped, `drop_cnt` = 1, `busy` falls at t+41.
- `rst` asserted while in EMIT holding 0x8A: `out_valid` = 0, `stable_keys` = 0, `drop_cnt` = 0 the next cycle.
- 300 dropped strobes: `drop_cnt` saturates at 0xFF.
